// File: rtl/nes_dma.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : nes_dma                                                   |
// | Function : two-channel CPU-bus DMA (block copy + DMC sample fetch)   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module nes_dma #(
    parameter logic [15:0] TRIG_ADDR = 16'h4014,
    parameter logic [15:0] DEST_ADDR = 16'h2004,
    parameter int          XFER_LEN  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        apu_cycle,
    input  logic        rw_i,
    input  logic [15:0] cpu_addr_i,
    input  logic [7:0]  cpu_data_i,
    input  logic [7:0]  bus_data_i,
    output logic [7:0]  cpu_data_o,
    output logic        dma_req,
    input  logic        dma_active,
    output logic [15:0] dma_address,
    output logic        dma_rw,
    input  logic        dmc_req,
    input  logic [15:0] dmc_addr,
    output logic        dmc_ack,
    output logic [7:0]  dmc_data
);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;
    localparam logic [8:0] c_last    = 9'(XFER_LEN - 1);

    logic [0:0]  r_state, w_state_nx;
    logic [15:0] r_base, w_base_nx;
    logic [8:0]  r_cnt, w_cnt_nx;
    logic        r_oam_busy, w_oam_busy_nx;
    logic        r_have_byte, w_have_byte_nx;
    logic        r_dmc_pend, w_dmc_pend_nx;
    logic        r_dmc_got, w_dmc_got_nx;
    logic [7:0]  r_dmc_data, w_dmc_data_nx;
    logic        w_trig, w_dmc_new, w_xfer;

    // A trigger cycle never moves data, even when the bus is granted.
    assign w_trig    = ~rst & ~rw_i & (cpu_addr_i == TRIG_ADDR) & ~r_oam_busy;
    assign w_dmc_new = ~rst & dmc_req & ~r_dmc_pend & ~r_dmc_got;
    assign w_xfer    = ~rst & (r_state == c_st_run) & dma_active & ~w_trig;
    assign dma_req   = ~rst & ((r_state == c_st_run) | w_trig);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_base      <= 16'h0000;
            r_cnt       <= 9'd0;
            r_oam_busy  <= 1'b0;
            r_have_byte <= 1'b0;
            r_dmc_pend  <= 1'b0;
            r_dmc_got   <= 1'b0;
            r_dmc_data  <= 8'h00;
        end else begin
            r_state     <= w_state_nx;
            r_base      <= w_base_nx;
            r_cnt       <= w_cnt_nx;
            r_oam_busy  <= w_oam_busy_nx;
            r_have_byte <= w_have_byte_nx;
            r_dmc_pend  <= w_dmc_pend_nx;
            r_dmc_got   <= w_dmc_got_nx;
            r_dmc_data  <= w_dmc_data_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_base_nx      = r_base;
        w_cnt_nx       = r_cnt;
        w_oam_busy_nx  = r_oam_busy;
        w_have_byte_nx = r_have_byte;
        w_dmc_pend_nx  = r_dmc_pend;
        w_dmc_got_nx   = r_dmc_got;
        w_dmc_data_nx  = r_dmc_data;
        dma_address    = 16'h0000;
        dma_rw         = rw_i;
        cpu_data_o     = cpu_data_i;
        dmc_ack        = 1'b0;
        dmc_data       = r_dmc_data;

        if (w_xfer) begin
            dma_rw = 1'b1;
            if (apu_cycle) begin
                // DMC owns the get slot; the block read waits for the next one.
                if (r_dmc_pend) begin
                    dma_address   = dmc_addr;
                    w_dmc_pend_nx = 1'b0;
                    w_dmc_got_nx  = 1'b1;
                end else if (r_oam_busy && !r_have_byte) begin
                    dma_address    = r_base + {7'd0, r_cnt};
                    w_have_byte_nx = 1'b1;
                end
            end else begin
                if (r_dmc_got) begin
                    dmc_ack       = 1'b1;
                    dmc_data      = bus_data_i;
                    w_dmc_data_nx = bus_data_i;
                    w_dmc_got_nx  = 1'b0;
                end else if (r_have_byte) begin
                    dma_address    = DEST_ADDR;
                    dma_rw         = 1'b0;
                    cpu_data_o     = bus_data_i;
                    w_cnt_nx       = r_cnt + 9'd1;
                    w_have_byte_nx = 1'b0;
                    if (r_cnt == c_last) begin
                        w_oam_busy_nx = 1'b0;
                    end
                end
            end
        end

        if (w_trig) begin
            w_base_nx     = {cpu_data_i, 8'h00};
            w_cnt_nx      = 9'd0;
            w_oam_busy_nx = 1'b1;
        end
        if (w_dmc_new) begin
            w_dmc_pend_nx = 1'b1;
        end

        if (r_state == c_st_idle) begin
            if (w_trig || w_dmc_new) begin
                w_state_nx = c_st_run;
            end
        end else if (!w_oam_busy_nx && !w_dmc_pend_nx && !w_dmc_got_nx) begin
            w_state_nx = c_st_idle;
        end
    end

endmodule
`default_nettype wire
